// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial adder controller: FSM encoding, slice width
// and the digit-counter width helper.
package serial_add_ctrl_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter needs clog2(digits) bits, but never fewer than one.
    function automatic int cntWidth(input int width);
        int digits;
        digits = width / DIGIT_W;
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_slice.sv
// Shared 2-bit adder slice with carry-in; purely combinational, y = a + b + cin.
module add2_slice (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic       i_cin,
    output logic [2:0] o_y
);

    assign o_y = {1'b0, i_a} + {1'b0, i_b} + {2'b00, i_cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer that adds two WIDTH-bit operands two bits per cycle through a single
// shared add2_slice, with start/done handshake and synchronous abort.
module serial_add_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH:0]   o_sum
);
    import serial_add_ctrl_pkg::*;

    localparam int            NDIG     = WIDTH / serial_add_ctrl_pkg::DIGIT_W;
    localparam int            CW       = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    generate
        if (DIGIT_W != serial_add_ctrl_pkg::DIGIT_W || WIDTH < 2 || (WIDTH % 2) != 0) begin : g_cfgError
            $error("serial_add_ctrl: DIGIT_W must be 2 and WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH:0]   r_sum;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_y;
    logic [WIDTH:0]   w_sumNext;

    add2_slice u_slice (
        .i_a   (r_a[1:0]),
        .i_b   (r_b[1:0]),
        .i_cin (r_carry),
        .o_y   (w_y)
    );

    // Drop the current slice result into the digit selected by the counter;
    // the final digit also deposits the carry-out as the sum MSB.
    always_comb begin
        w_sumNext = r_sum;
        for (int i = 0; i < NDIG; i++) begin
            if (r_cnt == CW'(i)) begin
                w_sumNext[2*i +: 2] = w_y[1:0];
            end
        end
        if (r_cnt == LAST_CNT) begin
            w_sumNext[WIDTH] = w_y[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort wins even on the last digit, so no done pulse escapes.
                    if (i_abort) begin
                        r_a     <= '0;
                        r_b     <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_sum   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_sum   <= w_sumNext;
                        r_carry <= w_y[2];
                        r_a     <= r_a >> DIGIT_W;
                        r_b     <= r_b >> DIGIT_W;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl: an 8-bit instance for the
// handshake, abort and reset scenarios and a 4-bit instance for an exhaustive sweep.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic       abort8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [8:0] sum8;

    logic       start4 = 1'b0;
    logic       abort4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4;
    logic       done4;
    logic [4:0] sum4;

    int         checkCount = 0;
    int         errorCount = 0;

    logic       tbBusy;
    logic       tbDone;
    logic [8:0] tbSum;
    int         doneSeen;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8), .DIGIT_W(2)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start8),
        .i_abort (abort8),
        .i_a     (a8),
        .i_b     (b8),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_sum   (sum8)
    );

    serial_add_ctrl #(.WIDTH(4), .DIGIT_W(2)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start4),
        .i_abort (abort4),
        .i_a     (a4),
        .i_b     (b4),
        .o_busy  (busy4),
        .o_done  (done4),
        .o_sum   (sum4)
    );

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive start and operands of the selected instance.
    task automatic applyStimulus(input bit useSmall, input logic start, input logic [7:0] a, input logic [7:0] b);
        if (useSmall) begin
            start4 = start;
            a4     = a[3:0];
            b4     = b[3:0];
        end else begin
            start8 = start;
            a8     = a;
            b8     = b;
        end
    endtask

    task automatic sampleOutputs(input bit useSmall, output logic busy, output logic done, output logic [8:0] sum);
        if (useSmall) begin
            busy = busy4;
            done = done4;
            sum  = {4'b0000, sum4};
        end else begin
            busy = busy8;
            done = done8;
            sum  = sum8;
        end
    endtask

    // One complete add: start pulse, then eight samples on falling edges.
    // done must appear exactly once, WIDTH/2 samples after the accept edge.
    task automatic runAdd(input bit useSmall, input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] expSum, input string tag);
        int       latency;
        int       doneCount;
        int       doneIdx;
        int       busyCount;
        logic     busy;
        logic     done;
        logic [8:0] sum;
        latency   = useSmall ? 2 : 4;
        doneCount = 0;
        doneIdx   = -1;
        busyCount = 0;
        @(negedge clk);
        applyStimulus(useSmall, 1'b1, a, b);
        @(negedge clk);
        applyStimulus(useSmall, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            sampleOutputs(useSmall, busy, done, sum);
            if (busy) busyCount++;
            if (done) begin
                doneCount++;
                doneIdx = i;
            end
        end
        checkOutput({tag, " sum"}, 32'(sum), 32'(expSum));
        checkOutput({tag, " doneCount"}, doneCount, 1);
        checkOutput({tag, " latency"}, doneIdx, latency);
        if (!useSmall) checkOutput({tag, " busyCycles"}, busyCount, latency + 1);
    endtask

    initial begin
        $display("[TB] serial_add_ctrl directed test starting");

        // Reset state while rst_n is held low
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset busy8", 32'(busy8), 0);
        checkOutput("reset done8", 32'(done8), 0);
        checkOutput("reset sum8", 32'(sum8), 0);
        checkOutput("reset busy4", 32'(busy4), 0);
        checkOutput("reset sum4", 32'(sum4), 0);
        rst_n = 1'b1;

        // FF + 01 carries all the way through
        runAdd(1'b0, 8'hFF, 8'h01, 9'h100, "ff+01");
        repeat (3) @(negedge clk);
        checkOutput("hold sum while idle", 32'(sum8), 32'h100);
        checkOutput("idle busy", 32'(busy8), 0);

        // Alternating patterns, then back-to-back carry-out case
        runAdd(1'b0, 8'hA5, 8'h5A, 9'h0FF, "a5+5a");
        runAdd(1'b0, 8'h80, 8'h80, 9'h100, "80+80");

        // start held high throughout; operands change every cycle after accept
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 8'h12, 8'h34);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sampleOutputs(1'b0, tbBusy, tbDone, tbSum);
            if (i == 4) begin
                checkOutput("held start done", 32'(tbDone), 1);
                checkOutput("held start sum", 32'(tbSum), 32'h046);
            end
            if (i == 5) checkOutput("held start idle gap", 32'(tbBusy), 0);
            if (i == 6) checkOutput("held start reaccept", 32'(tbBusy), 1);
            if (i == 10) begin
                checkOutput("second add done", 32'(tbDone), 1);
                checkOutput("second add sum", 32'(tbSum), 32'h023);
            end
            if (i < 5) applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i), 8'(8'h70 + i));
            else if (i == 5) applyStimulus(1'b0, 1'b1, 8'h20, 8'h03);
            else applyStimulus(1'b0, 1'b0, 8'hEE, 8'hEE);
        end

        // Abort on the third RUN cycle of FF + FF
        doneSeen = 0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sampleOutputs(1'b0, tbBusy, tbDone, tbSum);
            if (tbDone) doneSeen++;
            if (i == 0) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
            if (i == 1) checkOutput("abort partial sum d0", 32'(tbSum), 32'h002);
            if (i == 2) begin
                checkOutput("abort partial sum d1", 32'(tbSum), 32'h00E);
                abort8 = 1'b1;
            end
            if (i == 3) begin
                checkOutput("abort busy", 32'(tbBusy), 0);
                checkOutput("abort sum cleared", 32'(tbSum), 0);
                abort8 = 1'b0;
            end
        end
        checkOutput("abort no done", doneSeen, 0);
        runAdd(1'b0, 8'h0F, 8'h01, 9'h010, "after abort 0f+01");

        // Abort on the last digit must beat the transition to DONE
        doneSeen = 0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 8'h11, 8'h22);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sampleOutputs(1'b0, tbBusy, tbDone, tbSum);
            if (tbDone) doneSeen++;
            if (i == 0) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
            if (i == 3) abort8 = 1'b1;
            if (i == 4) begin
                abort8 = 1'b0;
                checkOutput("late abort sum", 32'(tbSum), 0);
            end
        end
        checkOutput("late abort no done", doneSeen, 0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 8'h55, 8'h55);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("pre-reset partial sum", 32'(sum8), 32'h002);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(busy8), 0);
        checkOutput("async reset done", 32'(done8), 0);
        checkOutput("async reset sum", 32'(sum8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done8) doneSeen++;
        end
        checkOutput("post reset no done", doneSeen, 0);
        checkOutput("post reset busy", 32'(busy8), 0);
        runAdd(1'b0, 8'h55, 8'h55, 9'h0AA, "after reset 55+55");

        // Exhaustive 4-bit sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                runAdd(1'b1, 8'(x), 8'(y), 9'(x + y), $sformatf("sweep4 %0d+%0d", x, y));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that adds two WIDTH-bit unsigned operands by reusing one 2-bit adder slice over WIDTH/2 clock cycles.
- The slice is the team's 2-bit adder extended with carry-in. The controller handles start/done, operand shifting, carry chaining, digit counting and abort.
- It sits between a requesting unit and the shared narrow adder, trading latency for area.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 2; result is WIDTH+1 bits.
- DIGIT_W, 2, bits processed per cycle; fixed at 2 because it matches the adder slice; any other value is a configuration error, flagged by a simulation-time check.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse or level; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in RUN.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; sum valid.
- sum  out  WIDTH+1  result {carry_out, sum_bits}; held until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, internal count, carry and operand registers=0. Reset mid-operation discards all work with no done pulse. After release, the block resumes from IDLE on the first rising edge.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with start=1:
  - latch a and b into shift registers; cnt=0; carry=0; sum=0.
  - start is ignored in RUN and DONE; there is no queueing.
- RUN, each edge:
  - slice inputs: the low 2 bits of the A and B shift registers plus carry; slice output is 3 bits.
  - write the 2 slice sum bits into sum[2*cnt+1 : 2*cnt].
  - carry <= slice bit 2; shift both operand registers right by 2; cnt++.
- RUN -> DONE when cnt == WIDTH/2-1 on the current edge: the last digit is written and sum[WIDTH] <= the final carry.
- DONE: done=1 for exactly one cycle, busy=1; the next edge returns to IDLE.
- abort=1 in RUN: next edge -> IDLE, sum cleared to 0, no done pulse.
  - abort has priority over the RUN->DONE transition on the same edge.
  - abort is ignored in IDLE and DONE.
- Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH/2 (WIDTH=8: done visible after the 5th edge counting the accept edge).
  - Back-to-back throughput: one result per WIDTH/2+2 cycles.
  - busy rises after the accepting edge and falls after the DONE edge.
- Arithmetic: unsigned, sum = a + b exactly, no overflow possible (WIDTH+1 result).
- All outputs are registered; no combinational path from inputs to outputs.
- cnt width: clog2(WIDTH/2), minimum 1 bit.

Decomposition:
- Shared header / package: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; DIGIT_W=2.
- One sub-module, add2_slice: combinational, inputs a[1:0], b[1:0], cin; output y[2:0] = a + b + cin. It is instantiated once; the controller owns all registers.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, start pulse -> busy high for 5 cycles; done pulse once; sum=9'h100; sum holds 9'h100 while idle.
- WIDTH=8, a=8'hA5, b=8'h5A -> sum=9'h0FF; then a=8'h80, b=8'h80 back-to-back -> sum=9'h100; each operation gives exactly one done pulse.
- start held high with new a/b for all of RUN -> operands from the accept edge only are used; the second add starts only after returning to IDLE.
- abort asserted on the 3rd RUN cycle of a=8'hFF, b=8'hFF -> no done pulse, sum=0, IDLE next edge; a following start with 8'h0F+8'h01 -> sum=9'h010.
- rst_n pulsed low mid-RUN, asynchronous to clk -> busy, done and sum drop to 0 immediately; no done pulse after release; a subsequent add is correct.
- WIDTH=4, exhaustive nested sweep of a, b over 0..15 -> sum == a+b for all 256 pairs; done latency is always 3 edges from accept.
